pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage of the MIPS pipeline, superseding the fixed 32-bit four-way PC mux. It adds stall/hold, fetch handshake, exception vectoring with EPC capture, misaligned-target trapping, and a return-address stack (RAS) that supplies predicted `jr` targets. It sits between the hazard/control unit and instruction memory.

---
 rtl/pc_gen.sv | 190 +++++++++++++++++++
 tb/tb_pc_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen -- program-counter generator for the fetch stage.
//
// Produces the fetch address each cycle from sequential, branch, jump, jr and
// exception sources. Misaligned redirect targets trap to EXC_VECTOR with the
// faulting target captured in epc_o. A small return-address stack (RAS)
// supplies predicted jr targets.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   stall_i               hold the PC
//   fetch_ready_i         instruction memory accepts pc_o this cycle
//   pc_src_i[2:0]         000 seq, 001 branch, 010 jump, 011 jr, 100 exception
//   branch/jump/jr_target redirect targets
//   ras_push_i/ras_data_i push a link address
//   ras_pop_i             pop the top entry
//   pc_o, pc_valid_o      registered fetch request
//   epc_o                 exception PC
//   misalign_o            one-cycle flag for a misaligned-target trap
//   ras_top_o, ras_valid_o  predicted return address and RAS non-empty
// -----------------------------------------------------------------------------
module pc_gen #(
   parameter int unsigned       ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
   parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'h8000_0180),
   parameter int unsigned       RAS_DEPTH    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_i,
   input  logic              fetch_ready_i,
   input  logic [2:0]        pc_src_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   input  logic [ADDR_W-1:0] jump_target_i,
   input  logic [ADDR_W-1:0] jr_target_i,
   input  logic              ras_push_i,
   input  logic [ADDR_W-1:0] ras_data_i,
   input  logic              ras_pop_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              pc_valid_o,
   output logic [ADDR_W-1:0] epc_o,
   output logic              misalign_o,
   output logic [ADDR_W-1:0] ras_top_o,
   output logic              ras_valid_o
);

   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(RAS_DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_reg;
   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic [ADDR_W-1:0] epc_reg, epc_next;
   logic              pc_valid_reg;
   logic              misalign_reg, misalign_next;
   logic [PTR_W-1:0]  ras_ptr_reg, ras_ptr_next;
   logic [CNT_W-1:0]  ras_cnt_reg, ras_cnt_next;

   logic              ras_we;
   logic [PTR_W-1:0]  ras_waddr;
   logic [PTR_W-1:0]  ptr_inc, ptr_dec;
   logic [ADDR_W-1:0] ras_entries [RAS_DEPTH];

   logic [ADDR_W-1:0] target;
   logic              is_exc, is_redirect, flush;

   // Circular pointer arithmetic over RAS_DEPTH entries (not necessarily a power of 2).
   assign ptr_inc = (ras_ptr_reg == LAST_IDX) ? '0 : ras_ptr_reg + PTR_W'(1);
   assign ptr_dec = (ras_ptr_reg == '0) ? LAST_IDX : ras_ptr_reg - PTR_W'(1);

   always_comb begin
      target      = '0;
      is_exc      = 1'b0;
      is_redirect = 1'b0;
      case (pc_src_i)
         3'b001:  begin target = branch_target_i; is_redirect = 1'b1; end
         3'b010:  begin target = jump_target_i;   is_redirect = 1'b1; end
         3'b011:  begin target = jr_target_i;     is_redirect = 1'b1; end
         3'b100:  is_exc = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      pc_next       = pc_reg;
      epc_next      = epc_reg;
      misalign_next = 1'b0;
      flush         = 1'b0;
      ras_ptr_next  = ras_ptr_reg;
      ras_cnt_next  = ras_cnt_reg;
      ras_we        = 1'b0;
      ras_waddr     = ptr_inc;

      if (state_reg == RUN) begin
         // Exceptions and redirects take effect regardless of stall/ready.
         if (is_exc) begin
            pc_next  = EXC_VECTOR;
            epc_next = pc_reg;
            flush    = 1'b1;
         end else if (is_redirect) begin
            if (target[1:0] != 2'b00) begin
               pc_next       = EXC_VECTOR;
               epc_next      = target;
               misalign_next = 1'b1;
               flush         = 1'b1;
            end else begin
               pc_next = target;
            end
         end else if (!stall_i && fetch_ready_i) begin
            pc_next = pc_reg + ADDR_W'(4);
         end

         if (flush) begin
            ras_ptr_next = '0;
            ras_cnt_next = '0;
         end else if (ras_push_i && ras_pop_i && ras_cnt_reg != '0) begin
            // Replace the top entry in place: pop then push nets to no movement.
            ras_we    = 1'b1;
            ras_waddr = ras_ptr_reg;
         end else if (ras_push_i) begin
            // When full, top+1 is the oldest entry, so it is overwritten.
            ras_we       = 1'b1;
            ras_waddr    = ptr_inc;
            ras_ptr_next = ptr_inc;
            if (ras_cnt_reg != FULL_CNT)
               ras_cnt_next = ras_cnt_reg + CNT_W'(1);
         end else if (ras_pop_i && ras_cnt_reg != '0) begin
            ras_ptr_next = ptr_dec;
            ras_cnt_next = ras_cnt_reg - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         pc_reg       <= RESET_VECTOR;
         epc_reg      <= '0;
         pc_valid_reg <= 1'b0;
         misalign_reg <= 1'b0;
         ras_ptr_reg  <= '0;
         ras_cnt_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               state_reg    <= RUN;
               pc_valid_reg <= 1'b1;
            end
            RUN: begin
               state_reg    <= RUN;
               pc_valid_reg <= 1'b1;
            end
            default: begin
               state_reg    <= IDLE;
               pc_valid_reg <= 1'b0;
            end
         endcase
         pc_reg       <= pc_next;
         epc_reg      <= epc_next;
         misalign_reg <= misalign_next;
         ras_ptr_reg  <= ras_ptr_next;
         ras_cnt_reg  <= ras_cnt_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
         logic [ADDR_W-1:0] entry_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               entry_reg <= '0;
            else if (ras_we && ras_waddr == PTR_W'(gi))
               entry_reg <= ras_data_i;
         end
         assign ras_entries[gi] = entry_reg;
      end
   endgenerate

   assign pc_o        = pc_reg;
   assign pc_valid_o  = pc_valid_reg;
   assign epc_o       = epc_reg;
   assign misalign_o  = misalign_reg;
   assign ras_valid_o = (ras_cnt_reg != '0);
   assign ras_top_o   = (ras_cnt_reg != '0) ? ras_entries[ras_ptr_reg] : '0;

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen (default parameters).
// A queue-based behavioural model is compared against the DUT on every
// falling edge; directed steps add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_pc_gen;

   localparam logic [31:0] EXC = 32'h8000_0180;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        stall_i = 1'b0;
   logic        fetch_ready_i = 1'b1;
   logic [2:0]  pc_src_i = 3'b000;
   logic [31:0] branch_target_i = '0;
   logic [31:0] jump_target_i = '0;
   logic [31:0] jr_target_i = '0;
   logic        ras_push_i = 1'b0;
   logic [31:0] ras_data_i = '0;
   logic        ras_pop_i = 1'b0;
   logic [31:0] pc_o, epc_o, ras_top_o;
   logic        pc_valid_o, misalign_o, ras_valid_o;

   int checks = 0;
   int failures = 0;

   pc_gen dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall_i         (stall_i),
      .fetch_ready_i   (fetch_ready_i),
      .pc_src_i        (pc_src_i),
      .branch_target_i (branch_target_i),
      .jump_target_i   (jump_target_i),
      .jr_target_i     (jr_target_i),
      .ras_push_i      (ras_push_i),
      .ras_data_i      (ras_data_i),
      .ras_pop_i       (ras_pop_i),
      .pc_o            (pc_o),
      .pc_valid_o      (pc_valid_o),
      .epc_o           (epc_o),
      .misalign_o      (misalign_o),
      .ras_top_o       (ras_top_o),
      .ras_valid_o     (ras_valid_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic        m_run = 1'b0;
   logic        m_valid = 1'b0;
   logic [31:0] m_pc = '0;
   logic [31:0] m_epc = '0;
   logic        m_mis = 1'b0;
   logic [31:0] m_ras[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run = 1'b0; m_valid = 1'b0; m_pc = '0; m_epc = '0; m_mis = 1'b0;
         m_ras.delete();
      end else if (!m_run) begin
         m_run = 1'b1; m_valid = 1'b1; m_mis = 1'b0;
      end else begin
         logic [31:0] tgt;
         logic        cleared;
         cleared = 1'b0;
         m_mis   = 1'b0;
         tgt = (pc_src_i == 3'd1) ? branch_target_i :
               (pc_src_i == 3'd2) ? jump_target_i : jr_target_i;
         if (pc_src_i == 3'd4) begin
            m_epc = m_pc; m_pc = EXC; cleared = 1'b1;
         end else if (pc_src_i >= 3'd1 && pc_src_i <= 3'd3) begin
            if (tgt % 4 != 0) begin
               m_epc = tgt; m_pc = EXC; m_mis = 1'b1; cleared = 1'b1;
            end else begin
               m_pc = tgt;
            end
         end else if (!stall_i && fetch_ready_i) begin
            m_pc = m_pc + 32'd4;
         end
         if (cleared) m_ras.delete();
         else if (ras_push_i && ras_pop_i && m_ras.size() > 0) m_ras[m_ras.size()-1] = ras_data_i;
         else if (ras_push_i) begin
            if (m_ras.size() == 4) void'(m_ras.pop_front());
            m_ras.push_back(ras_data_i);
         end else if (ras_pop_i && m_ras.size() > 0) void'(m_ras.pop_back());
      end
   end

   // One compare per falling edge against the model.
   always @(negedge clk) begin
      chk("cyc_pc", pc_o, m_pc);
      chk("cyc_valid", {31'd0, pc_valid_o}, {31'd0, m_valid});
      chk("cyc_epc", epc_o, m_epc);
      chk("cyc_misalign", {31'd0, misalign_o}, {31'd0, m_mis});
      chk("cyc_ras_valid", {31'd0, ras_valid_o}, (m_ras.size() > 0) ? 32'd1 : 32'd0);
      chk("cyc_ras_top", ras_top_o, (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'd0);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      #1 rst_n = 1'b0;
      step(); step();
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_valid", {31'd0, pc_valid_o}, 32'd0);

      // 1. reset release and sequential fetch
      @(posedge clk); #1 rst_n = 1'b1;
      step(); chk("idle_valid", {31'd0, pc_valid_o}, 32'd0); chk("idle_pc", pc_o, 32'h0);
      step(); chk("run_valid", {31'd0, pc_valid_o}, 32'd1); chk("seq_pc0", pc_o, 32'h0);
      step(); chk("seq_pc4", pc_o, 32'h4);
      step(); chk("seq_pc8", pc_o, 32'h8);
      step(); chk("seq_pc12", pc_o, 32'hC);
      step(); chk("seq_pc16", pc_o, 32'h10);

      // 2. stall, redirect during stall, fetch not ready
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin step(); chk("stall_hold", pc_o, 32'h10); end
      pc_src_i = 3'd1; branch_target_i = 32'h40;
      step(); chk("branch_over_stall", pc_o, 32'h40);
      pc_src_i = 3'd0; stall_i = 1'b0; fetch_ready_i = 1'b0;
      step(); chk("notready_hold", pc_o, 32'h40);
      step(); chk("notready_hold2", pc_o, 32'h40);
      fetch_ready_i = 1'b1;
      step(); chk("ready_resume", pc_o, 32'h44);

      // 3. exception and misaligned jump
      pc_src_i = 3'd3; jr_target_i = 32'h24;
      step(); chk("jr_pc", pc_o, 32'h24);
      pc_src_i = 3'd4;
      step(); chk("exc_pc", pc_o, EXC); chk("exc_epc", epc_o, 32'h24);
      chk("exc_nomis", {31'd0, misalign_o}, 32'd0);
      pc_src_i = 3'd2; jump_target_i = 32'h102;
      step(); chk("mis_pc", pc_o, EXC); chk("mis_epc", epc_o, 32'h102);
      chk("mis_flag", {31'd0, misalign_o}, 32'd1);
      pc_src_i = 3'd0;
      step(); chk("mis_pulse_end", {31'd0, misalign_o}, 32'd0); chk("after_exc_seq", pc_o, 32'h8000_0184);

      // 4. wrap-around
      pc_src_i = 3'd3; jr_target_i = 32'hFFFF_FFFC;
      step(); chk("wrap_jr", pc_o, 32'hFFFF_FFFC);
      pc_src_i = 3'd0;
      step(); chk("wrap_pc", pc_o, 32'h0);

      // 5. RAS
      ras_push_i = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         ras_data_i = 32'(i) * 32'h100;
         step(); chk("ras_push_top", ras_top_o, 32'(i) * 32'h100);
      end
      ras_push_i = 1'b0; ras_pop_i = 1'b1;
      for (int i = 4; i >= 2; i--) begin
         step(); chk("ras_pop_top", ras_top_o, 32'(i) * 32'h100);
      end
      step(); chk("ras_empty_valid", {31'd0, ras_valid_o}, 32'd0); chk("ras_empty_top", ras_top_o, 32'h0);
      step(); chk("ras_pop_empty", {31'd0, ras_valid_o}, 32'd0);
      ras_pop_i = 1'b0; ras_push_i = 1'b1;
      ras_data_i = 32'h700; step();
      ras_data_i = 32'h800; step();
      ras_data_i = 32'h600; ras_pop_i = 1'b1;
      step(); chk("ras_pushpop_top", ras_top_o, 32'h600);
      ras_push_i = 1'b0;
      step(); chk("ras_cnt2_pop", ras_top_o, 32'h700); chk("ras_cnt2_valid", {31'd0, ras_valid_o}, 32'd1);
      step(); chk("ras_cnt2_empty", {31'd0, ras_valid_o}, 32'd0);
      ras_pop_i = 1'b0; ras_push_i = 1'b1; ras_data_i = 32'h10;
      step(); chk("ras_pre_exc", ras_top_o, 32'h10);
      pc_src_i = 3'd4; ras_data_i = 32'h20;
      step(); chk("ras_exc_clear", {31'd0, ras_valid_o}, 32'd0);
      pc_src_i = 3'd0; ras_push_i = 1'b0;

      // 6. reset mid-run
      ras_push_i = 1'b1; ras_data_i = 32'h1000; step();
      ras_data_i = 32'h2000; step();
      ras_data_i = 32'h3000; pc_src_i = 3'd3; jr_target_i = 32'h48;
      step(); chk("mid_pc", pc_o, 32'h48); chk("mid_ras_top", ras_top_o, 32'h3000);
      ras_push_i = 1'b0; pc_src_i = 3'd0; stall_i = 1'b1;
      #2 rst_n = 1'b0;
      #1 chk("mid_rst_pc", pc_o, 32'h0); chk("mid_rst_valid", {31'd0, pc_valid_o}, 32'd0);
      chk("mid_rst_ras", {31'd0, ras_valid_o}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1; stall_i = 1'b0;
      step(); chk("rel_idle_valid", {31'd0, pc_valid_o}, 32'd0); chk("rel_idle_pc", pc_o, 32'h0);
      step(); chk("rel_run_valid", {31'd0, pc_valid_o}, 32'd1); chk("rel_pc0", pc_o, 32'h0);
      step(); chk("rel_pc4", pc_o, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
